// File: rtl/nibble_sub16.sv
// rtl/nibble_sub16.sv - 16-bit subtractor, one nibble per cycle through a 4-bit carry-lookahead slice
module nibble_sub16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] diff,
   output logic        borrow,
   output logic        ovf,
   output logic        zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_a;
   logic [15:0] r_nb;
   logic        r_carry;
   logic [1:0]  r_idx;
   logic [15:0] r_part;
   logic [15:0] r_diff;
   logic        r_borrow;
   logic        r_ovf;
   logic        r_zero;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_x;
   logic [3:0]  w_y;
   logic [3:0]  w_g;
   logic [3:0]  w_p;
   logic [4:0]  w_c;
   logic [3:0]  w_sum;
   logic [15:0] w_final;

   // Lookahead carries computed directly from g/p, not rippled
   always_comb begin
      w_x   = r_a[{r_idx, 2'b00} +: 4];
      w_y   = r_nb[{r_idx, 2'b00} +: 4];
      w_g   = w_x & w_y;
      w_p   = w_x ^ w_y;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & r_carry);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
      w_sum   = w_p ^ w_c[3:0];
      w_final = {w_sum, r_part[11:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_a      <= 16'h0000;
         r_nb     <= 16'h0000;
         r_carry  <= 1'b0;
         r_idx    <= 2'd0;
         r_part   <= 16'h0000;
         r_diff   <= 16'h0000;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_a     <= a;
                  r_nb    <= ~b;
                  r_carry <= 1'b1;
                  r_idx   <= 2'd0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_part[{r_idx, 2'b00} +: 4] <= w_sum;
               r_carry <= w_c[4];
               r_idx   <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  // Results only become visible here, never mid-operation
                  r_state  <= ST_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_diff   <= w_final;
                  r_borrow <= ~w_c[4];
                  r_ovf    <= (r_a[15] == r_nb[15]) && (w_final[15] != r_a[15]);
                  r_zero   <= (w_final == 16'h0000);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign ovf    = r_ovf;
   assign zero   = r_zero;

endmodule

// File: tb/tb_nibble_sub16.sv
// tb/tb_nibble_sub16.sv - table-driven bench for nibble_sub16 plus hand-written multi-cycle sequences
module tb_nibble_sub16;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        borrow;
   logic        ovf;
   logic        zero;

   int checks;
   int errors;
   logic [15:0] prev_diff;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] ediff;
      logic        eborrow;
      logic        eovf;
      logic        ezero;
   } vec_t;

   vec_t vecs[8];

   nibble_sub16 dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Entered at a negedge; returns at the negedge after the done cycle
   task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ediff, input logic eb,
                         input logic eo, input logic ez);
      int lat;
      lat = 99;
      start = 1'b1;
      a = va;
      b = vb;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, 1);
         end
         if (k == 2) chk("diff_stable_in_run", diff, prev_diff);
         if (done) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, 5);
      chk("diff", diff, ediff);
      chk("borrow", borrow, eb);
      chk("ovf", ovf, eo);
      chk("zero", zero, ez);
      chk("busy_in_done", busy, 0);
      @(negedge clk);
      chk("done_single_pulse", done, 0);
      prev_diff = diff;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      prev_diff = 16'h0000;
      reset = 1'b1;
      start = 1'b0;
      a = 16'h0000;
      b = 16'h0000;

      vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{16'h00F0, 16'h000F, 16'h00E1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0};

      start = 1'b1;
      a = 16'hFFFF;
      b = 16'h0001;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 16'h0000);
      chk("rst_borrow", borrow, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_zero", zero, 0);

      // Start on the very first edge after reset release
      reset = 1'b0;
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].va, vecs[i].vb, vecs[i].ediff, vecs[i].eborrow, vecs[i].eovf, vecs[i].ezero);

      // Start re-pulsed during RUN must be ignored
      begin
         int pulses;
         pulses = 0;
         start = 1'b1;
         a = 16'h0010;
         b = 16'h0001;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         start = 1'b1;
         a = 16'hFFFF;
         b = 16'h1234;
         @(negedge clk);
         start = 1'b0;
         for (int k = 0; k < 10; k++) begin
            if (done) begin
               pulses++;
               chk("ignore_diff", diff, 16'h000F);
               chk("ignore_borrow", borrow, 0);
            end
            @(negedge clk);
         end
         chk("ignore_pulses", pulses, 1);
      end

      // Start held high: done every 5th cycle, busy low only then
      begin
         int pulses;
         pulses = 0;
         start = 1'b1;
         a = 16'h0003;
         b = 16'h0005;
         for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("held_done", done, (k % 5) == 0);
            chk("held_busy", busy, (k % 5) != 0);
            if (done) begin
               pulses++;
               chk("held_diff", diff, 16'hFFFE);
               chk("held_borrow", borrow, 1);
            end
         end
         start = 1'b0;
         chk("held_pulses", pulses, 3);
         @(negedge clk);
         chk("held_idle", busy, 0);
      end

      // Reset during the second RUN cycle aborts with no done
      begin
         int pulses;
         pulses = 0;
         start = 1'b1;
         a = 16'h1234;
         b = 16'h0234;
         @(negedge clk);
         start = 1'b0;
         chk("abort_busy_before", busy, 1);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
         chk("abort_diff", diff, 16'h0000);
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) pulses++;
         end
         chk("abort_no_done", pulses, 0);
         prev_diff = 16'h0000;
         run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
